// File: rtl/frame_composer_if.sv
// Frame output handshake bundle: composed frame, its valid strobe and the consumer's ready.
interface frame_composer_if #(
   parameter int DATA_W = 192
);
   logic              frame_valid;
   logic              frame_ready;
   logic [DATA_W-1:0] frame_data;

   modport master (output frame_valid, output frame_data, input frame_ready);
   modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/frame_composer.sv
// Builds one LED-matrix frame (bricks, paddle, ball or game-over image) row by row from a
// snapshot taken at frame_tick. Optional game-over blinking: define FRAME_COMPOSER_BLINK_EN.
//
// state | meaning
// IDLE  | waiting for frame_tick; accepts the tick and snapshots all game inputs
// BUILD | writes one row per cycle into the work buffer, rows 0..ROWS-1
// HOLD  | frame_data/frame_valid held until the consumer handshakes
module frame_composer #(
   parameter int ROWS         = 12,
   parameter int COLS         = 16,
   parameter int BRICK_ROWS   = 7,
   parameter int BRICK_COLS   = 8,
   parameter int PLATE_ROW    = 10,
   parameter int BLINK_FRAMES = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             frame_tick,
   input  logic [COLS-1:0]                  plate_row,
   input  logic [3:0]                       ball_row,
   input  logic [3:0]                       ball_col,
   input  logic [BRICK_ROWS*BRICK_COLS-1:0] bricks,
   input  logic                             is_game_over,
   input  logic [ROWS*COLS-1:0]             gameover_img,
   frame_composer_if.master                 frame,
   output logic                             busy,
   output logic [7:0]                       drop_cnt
);

   localparam int BRICK_W = COLS / BRICK_COLS;
   localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int NB      = BRICK_ROWS * BRICK_COLS;
   localparam int FW      = ROWS * COLS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_cnt;
   logic [COLS-1:0] snap_plate;
   logic [3:0]      snap_ball_row;
   logic [3:0]      snap_ball_col;
   logic [NB-1:0]   snap_bricks;
   logic            snap_go;
   logic [FW-1:0]   snap_img;
   logic [FW-1:0]   work_q, work_d;
   logic [FW-1:0]   data_q;
   logic            valid_q;
   logic            load, last_row, hs, drop;
   logic [COLS-1:0] row_pix;

`ifdef FRAME_COMPOSER_BLINK_EN
   localparam int CW = $clog2(BLINK_FRAMES + 1);
   logic          blink_phase;
   logic [CW-1:0] blink_cnt;
`endif

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      hs       = 1'b0;
      drop     = 1'b0;
      last_row = (int'(row_cnt) == ROWS - 1);
      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               load    = 1'b1;
               state_d = BUILD;
            end
         end
         BUILD: begin
            drop = frame_tick;
            if (last_row) state_d = HOLD;
         end
         HOLD: begin
            drop = frame_tick;
            if (valid_q && frame.frame_ready) begin
               hs      = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pixel column c lives at bit COLS-1-c of its row, so column 0 is the row's MSB.
   always_comb begin
      int ri;
      int br;
      int bc;
      ri      = int'(row_cnt);
      br      = int'(snap_ball_row);
      bc      = int'(snap_ball_col);
      row_pix = '0;
      if (snap_go) begin
`ifdef FRAME_COMPOSER_BLINK_EN
         if (!blink_phase) row_pix = snap_img[(ROWS-1-ri)*COLS +: COLS];
`else
         row_pix = snap_img[(ROWS-1-ri)*COLS +: COLS];
`endif
      end else begin
         if (ri < BRICK_ROWS) begin
            for (int c = 0; c < COLS; c++)
               row_pix[COLS-1-c] = snap_bricks[ri*BRICK_COLS + c/BRICK_W];
         end
         if (ri == PLATE_ROW) row_pix = row_pix | snap_plate;
         if (br == ri && br < ROWS && bc < COLS) row_pix[COLS-1-bc] = 1'b1;
      end
      work_d = work_q;
      work_d[(ROWS-1-ri)*COLS +: COLS] = row_pix;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         row_cnt       <= '0;
         snap_plate    <= '0;
         snap_ball_row <= '0;
         snap_ball_col <= '0;
         snap_bricks   <= '0;
         snap_go       <= 1'b0;
         snap_img      <= '0;
         work_q        <= '0;
         data_q        <= '0;
         valid_q       <= 1'b0;
         drop_cnt      <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            snap_plate    <= plate_row;
            snap_ball_row <= ball_row;
            snap_ball_col <= ball_col;
            snap_bricks   <= bricks;
            snap_go       <= is_game_over;
            snap_img      <= gameover_img;
            row_cnt       <= '0;
         end
         if (state_q == BUILD) begin
            work_q  <= work_d;
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            // The last row goes straight from work_d so the frame appears the same cycle.
            if (last_row) begin
               data_q  <= work_d;
               valid_q <= 1'b1;
            end
         end
         if (hs) valid_q <= 1'b0;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

`ifdef FRAME_COMPOSER_BLINK_EN
   // Phase only moves on a handshake, so it is constant across any single build.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_phase <= 1'b0;
         blink_cnt   <= '0;
      end else if (load && !is_game_over) begin
         blink_phase <= 1'b0;
         blink_cnt   <= '0;
      end else if (hs && snap_go) begin
         if (int'(blink_cnt) == BLINK_FRAMES - 1) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
`endif

   assign busy              = (state_q != IDLE);
   assign frame.frame_valid = valid_q;
   assign frame.frame_data  = data_q;

endmodule

// File: tb/tb_frame_composer.sv
// Directed self-checking bench for frame_composer; expectations follow FRAME_COMPOSER_BLINK_EN.
module tb_frame_composer;
   localparam int ROWS = 12;
   localparam int COLS = 16;
   localparam int FW   = ROWS * COLS;
`ifdef FRAME_COMPOSER_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_tick;
   logic [15:0]   plate_row;
   logic [3:0]    ball_row, ball_col;
   logic [55:0]   bricks;
   logic          is_game_over;
   logic [FW-1:0] gameover_img;
   logic          busy;
   logic [7:0]    drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [FW-1:0] exp_normal;

   frame_composer_if #(.DATA_W(FW)) fif ();

   frame_composer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick   (frame_tick),
      .plate_row    (plate_row),
      .ball_row     (ball_row),
      .ball_col     (ball_col),
      .bricks       (bricks),
      .is_game_over (is_game_over),
      .gameover_img (gameover_img),
      .frame        (fif.master),
      .busy         (busy),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic set_normal();
      bricks       = {56{1'b1}};
      plate_row    = 16'h0FF0;
      ball_row     = 4'd5;
      ball_col     = 4'd3;
      is_game_over = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // lat counts the tick-sampling edge as 1; the frame is expected after edge 13.
   task automatic run_frame(input bit chg, output int lat);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      lat = 1;
      while (fif.frame_valid !== 1'b1 && lat < 40) begin
         if (chg && lat == 4) begin
            bricks       = '0;
            plate_row    = 16'hFFFF;
            ball_row     = 4'd0;
            ball_col     = 4'd0;
            is_game_over = 1'b1;
         end
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic ack();
      @(negedge clk);
      fif.frame_ready = 1'b1;
      @(posedge clk);
      #1;
      fif.frame_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if (fif.frame_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b want 0", fif.frame_valid);
      end
      checks++;
      if (fif.frame_data !== '0) begin
         errors++; $display("FAIL reset_data: got %h want 0", fif.frame_data);
      end
      checks++;
      if (busy !== 1'b0 || drop_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_busy_drop: got busy=%b drop=%0d want 0/0", busy, drop_cnt);
      end
   endtask

   task automatic test_normal_frame();
      int lat;
      set_normal();
      run_frame(1'b0, lat);
      checks++;
      if (lat !== 13) begin
         errors++; $display("FAIL normal_latency: got %0d want 13", lat);
      end
      checks++;
      if (fif.frame_data !== exp_normal) begin
         errors++; $display("FAIL normal_data: got %h want %h", fif.frame_data, exp_normal);
      end
      checks++;
      if (fif.frame_data[99] !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL normal_bit99_busy: got bit99=%b busy=%b want 1/1", fif.frame_data[99], busy);
      end
      ack();
      checks++;
      if (fif.frame_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL normal_ack: got valid=%b busy=%b want 0/0", fif.frame_valid, busy);
      end
   endtask

   task automatic test_single_brick();
      int lat;
      bricks    = 56'h1;
      plate_row = 16'h0;
      ball_row  = 4'd12;
      ball_col  = 4'd0;
      run_frame(1'b0, lat);
      checks++;
      if (fif.frame_data !== {16'hC000, 176'h0}) begin
         errors++; $display("FAIL single_brick: got %h want %h", fif.frame_data, {16'hC000, 176'h0});
      end
      checks++;
      if (fif.frame_data[191:190] !== 2'b11) begin
         errors++; $display("FAIL single_brick_bits: got %b want 11", fif.frame_data[191:190]);
      end
      ack();
   endtask

   task automatic test_ball();
      logic [3:0]    br [6];
      logic [3:0]    bc [6];
      logic [FW-1:0] ex [6];
      int lat;
      br[0] = 4'd9;  bc[0] = 4'd3;  ex[0] = {144'h0, 16'h1000, 16'h0FF0, 16'h0};
      br[1] = 4'd11; bc[1] = 4'd15; ex[1] = {160'h0, 16'h0FF0, 16'h0001};
      br[2] = 4'd12; bc[2] = 4'd0;  ex[2] = {160'h0, 16'h0FF0, 16'h0};
      br[3] = 4'd15; bc[3] = 4'd15; ex[3] = {160'h0, 16'h0FF0, 16'h0};
      br[4] = 4'd10; bc[4] = 4'd4;  ex[4] = {160'h0, 16'h0FF0, 16'h0};
      br[5] = 4'd0;  bc[5] = 4'd0;  ex[5] = {16'h8000, 144'h0, 16'h0FF0, 16'h0};
      for (int i = 0; i < 6; i++) begin
         bricks       = '0;
         plate_row    = 16'h0FF0;
         is_game_over = 1'b0;
         ball_row     = br[i];
         ball_col     = bc[i];
         run_frame(1'b0, lat);
         checks++;
         if (fif.frame_data !== ex[i]) begin
            errors++; $display("FAIL ball_%0d_%0d: got %h want %h", br[i], bc[i], fif.frame_data, ex[i]);
         end
         ack();
      end
   endtask

   task automatic test_input_freeze();
      int lat;
      set_normal();
      run_frame(1'b1, lat);
      checks++;
      if (fif.frame_data !== exp_normal) begin
         errors++; $display("FAIL input_freeze: got %h want %h", fif.frame_data, exp_normal);
      end
      ack();
      set_normal();
   endtask

   task automatic test_hold_drop();
      int lat;
      int unstable;
      logic [FW-1:0] held;
      do_reset();
      set_normal();
      run_frame(1'b0, lat);
      held     = fif.frame_data;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         frame_tick = (i == 3 || i == 8 || i == 13);
         bricks     = 56'(i);
         @(posedge clk);
         #1;
         if (fif.frame_data !== held || fif.frame_valid !== 1'b1) unstable++;
      end
      frame_tick = 1'b0;
      set_normal();
      checks++;
      if (unstable !== 0 || held !== exp_normal) begin
         errors++; $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable);
      end
      checks++;
      if (drop_cnt !== 8'd3) begin
         errors++; $display("FAIL hold_drop_cnt: got %0d want 3", drop_cnt);
      end
      @(negedge clk);
      fif.frame_ready = 1'b1;
      frame_tick      = 1'b1;
      @(posedge clk);
      #1;
      fif.frame_ready = 1'b0;
      frame_tick      = 1'b0;
      checks++;
      if (drop_cnt !== 8'd4 || busy !== 1'b0 || fif.frame_valid !== 1'b0) begin
         errors++; $display("FAIL hold_ack_tick: got drop=%0d busy=%b valid=%b want 4/0/0",
                            drop_cnt, busy, fif.frame_valid);
      end
      run_frame(1'b0, lat);
      checks++;
      if (lat !== 13) begin
         errors++; $display("FAIL hold_next_frame: got latency %0d want 13", lat);
      end
      ack();
   endtask

   task automatic test_drop_saturate();
      int lat;
      run_frame(1'b0, lat);
      @(negedge clk);
      frame_tick = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      frame_tick = 1'b0;
      checks++;
      if (drop_cnt !== 8'd255) begin
         errors++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
      end
      ack();
   endtask

   task automatic test_reset_mid_build();
      int lat;
      set_normal();
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fif.frame_valid !== 1'b0 || fif.frame_data !== '0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
         errors++; $display("FAIL midbuild_reset: got valid=%b data=%h busy=%b drop=%0d want all 0",
                            fif.frame_valid, fif.frame_data, busy, drop_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1'b0, lat);
      checks++;
      if (lat !== 13 || fif.frame_data !== exp_normal) begin
         errors++; $display("FAIL midbuild_recover: got lat=%0d data=%h want 13 %h", lat, fif.frame_data, exp_normal);
      end
      ack();
   endtask

   task automatic test_game_over();
      int lat;
      logic [FW-1:0] exp;
      for (int r = 0; r < ROWS; r++)
         gameover_img[(ROWS-1-r)*COLS +: COLS] = 16'hA5C3 ^ (16'(r) * 16'h1111);
      set_normal();
      is_game_over = 1'b1;
      for (int i = 1; i <= 19; i++) begin
         run_frame(1'b0, lat);
         exp = (BLINK_ON && i > 8 && i <= 16) ? '0 : gameover_img;
         checks++;
         if (fif.frame_data !== exp) begin
            errors++; $display("FAIL gameover_frame_%0d: got %h want %h", i, fif.frame_data, exp);
         end
         ack();
      end
      is_game_over = 1'b0;
      run_frame(1'b0, lat);
      ack();
      is_game_over = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         run_frame(1'b0, lat);
         exp = (BLINK_ON && i == 9) ? '0 : gameover_img;
         checks++;
         if (fif.frame_data !== exp) begin
            errors++; $display("FAIL gameover_after_normal_%0d: got %h want %h", i, fif.frame_data, exp);
         end
         ack();
      end
      is_game_over = 1'b0;
   endtask

   initial begin
      exp_normal      = {{7{16'hFFFF}}, 48'h0, 16'h0FF0, 16'h0};
      rst_n           = 1'b0;
      frame_tick      = 1'b0;
      fif.frame_ready = 1'b0;
      plate_row       = '0;
      ball_row        = '0;
      ball_col        = '0;
      bricks          = '0;
      is_game_over    = 1'b0;
      gameover_img    = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_normal_frame();
      test_single_brick();
      test_ball();
      test_input_freeze();
      test_hold_drop();
      test_drop_saturate();
      test_reset_mid_build();
      test_game_over();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
